ov7670_capture: RTL and testbench

- Pixel capture stage directly downstream of the OV7670 configuration/SCCB block.
- Receives the camera's parallel DVP bus (VSYNC, HREF, D[7:0]) clocked by PCLK.
- Assembles byte pairs into RGB565 pixels and emits them, with a linear frame-buffer write address, to the frame-buffer writer feeding the Sobel pipeline.
- Does not capture until the configuration block reports done. Then captures only whole frames and flags malformed ones.

---
 rtl/ov7670_capture.sv | 107 ++++++++++
 tb/tb_ov7670_capture.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture.sv
// ov7670_capture: OV7670 DVP capture, RGB565 byte-pair assembly with linear frame-buffer addressing
module ov7670_capture #(
  parameter int H_PIX  = 640,
  parameter int V_PIX  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              conf_done_i,
  input  logic              enable_i,
  input  logic              vsync_i,
  input  logic              href_i,
  input  logic [7:0]        data_i,
  output logic [15:0]       pix_o,
  output logic              pix_valid_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              frame_start_o,
  output logic              frame_done_o,
  output logic [7:0]        frame_cnt_o,
  output logic              capturing_o,
  output logic              err_o
);
  localparam int CW = $clog2(H_PIX + 1);
  localparam int LW = $clog2(V_PIX + 2);
  localparam logic [CW-1:0] H_END = CW'(H_PIX);
  localparam logic [LW-1:0] V_END = LW'(V_PIX);
  localparam logic [LW-1:0] L_SAT = LW'(V_PIX + 1);
  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, DONE} state_t;
  state_t state, state_n;
  logic vs_r, hr_r, vs_q, hr_q;
  logic [7:0] d_r, hi;
  logic phase, pend;
  logic [CW-1:0] col;
  logic [LW-1:0] line;
  logic [ADDR_W-1:0] addr, a_d;
  logic [15:0] p_d;
  logic vs_fall, vs_rise, hr_fall, act, start, pix_evt, pix_bad, line_end, frame_end;
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = conf_done_i && enable_i ? SYNC : IDLE;
      SYNC:    state_n = !enable_i ? IDLE : vs_fall ? ACTIVE : SYNC;
      ACTIVE:  state_n = vs_rise ? DONE : ACTIVE;
      default: state_n = enable_i ? SYNC : IDLE;
    endcase
  end
  always_comb begin
    vs_fall     = vs_q & ~vs_r;
    vs_rise     = ~vs_q & vs_r;
    hr_fall     = hr_q & ~hr_r;
    act         = state == ACTIVE;
    capturing_o = act;
    start       = state == SYNC && enable_i && vs_fall;
    pix_evt     = act && hr_r && phase;
    pix_bad     = col >= H_END || line >= V_END;
    line_end    = act && hr_fall;
    frame_end   = act && vs_rise;
  end
  // Two-stage pixel path: stage 1 forms and addresses the pixel, stage 2 presents it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {vs_r, hr_r, vs_q, hr_q, d_r} <= '0;
      {hi, phase, pend, col, line, addr, a_d, p_d} <= '0;
      {pix_o, pix_valid_o, wr_addr_o, frame_start_o, frame_done_o, frame_cnt_o, err_o} <= '0;
    end else begin
      vs_r          <= vsync_i;
      hr_r          <= href_i;
      d_r           <= data_i;
      vs_q          <= vs_r;
      hr_q          <= hr_r;
      pend          <= pix_evt && !pix_bad;
      pix_valid_o   <= pend;
      frame_start_o <= start;
      frame_done_o  <= frame_end;
      if (pend) begin
        pix_o     <= p_d;
        wr_addr_o <= a_d;
      end
      if (start) begin
        phase <= 1'b0;
        col   <= '0;
        line  <= '0;
        addr  <= '0;
      end else if (act) begin
        if (hr_r) phase <= ~phase;
        if (hr_r && !phase) hi <= d_r;
        if (pix_evt && !pix_bad) begin
          p_d  <= {hi, d_r};
          a_d  <= addr;
          addr <= addr + ADDR_W'(1);
          col  <= col + CW'(1);
        end
        if (line_end) begin
          phase <= 1'b0;
          col   <= '0;
          if (line != L_SAT) line <= line + LW'(1);
        end
      end
      if ((pix_evt && pix_bad) || (line_end && (col != H_END || phase)) || (frame_end && line != V_END))
        err_o <= 1'b1;
      if (frame_end) frame_cnt_o <= frame_cnt_o + 8'd1;
    end
  end
endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: directed DVP frames against ov7670_capture with H_PIX=4, V_PIX=3
module tb_ov7670_capture;
  logic clk_i = 0, rst_i = 1, conf_done_i = 0, enable_i = 0;
  logic vsync_i = 0, href_i = 0;
  logic [7:0] data_i = 0;
  logic [15:0] pix_o;
  logic pix_valid_o, frame_start_o, frame_done_o, capturing_o, err_o;
  logic [3:0] wr_addr_o;
  logic [7:0] frame_cnt_o;
  int vec = 0, bad = 0, cyc = 0;
  int n_start = 0, n_done = 0, n_cap = 0;
  logic [15:0] pq[$];
  int aq[$], cq[$], bq[$];
  int ps, ss, ds, cs;

  ov7670_capture #(.H_PIX(4), .V_PIX(3), .ADDR_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .conf_done_i(conf_done_i), .enable_i(enable_i),
    .vsync_i(vsync_i), .href_i(href_i), .data_i(data_i), .pix_o(pix_o),
    .pix_valid_o(pix_valid_o), .wr_addr_o(wr_addr_o), .frame_start_o(frame_start_o),
    .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o), .capturing_o(capturing_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  always @(posedge clk_i) begin
    #1;
    if (pix_valid_o) begin
      pq.push_back(pix_o);
      aq.push_back(int'(wr_addr_o));
      cq.push_back(cyc);
    end
    if (frame_start_o) n_start++;
    if (frame_done_o) n_done++;
    if (capturing_o) n_cap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    ps = pq.size(); ss = n_start; ds = n_done; cs = n_cap;
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, " outs"}, {pix_o, 4'(wr_addr_o), frame_cnt_o, pix_valid_o, frame_start_o,
                        frame_done_o, capturing_o, err_o}, 0);
  endtask

  // short_ln: line with 7 bytes; en_ln: raise enable at that line; abort_ln: stop mid-line
  task automatic frame(input int nl, input int short_ln, input int en_ln, input int abort_ln);
    int b = 0;
    @(negedge clk_i) vsync_i = 1;
    repeat (2) @(negedge clk_i);
    @(negedge clk_i) vsync_i = 0;
    repeat (2) @(negedge clk_i);
    for (int l = 0; l < nl; l++) begin
      if (l == en_ln) enable_i = 1;
      for (int j = 0; j < ((l == short_ln) ? 7 : 8); j++) begin
        @(negedge clk_i);
        href_i = 1;
        data_i = 8'(b);
        if (j % 2 == 1) bq.push_back(cyc + 1);
        b++;
        if (l == abort_ln && j == 4) return;
      end
      @(negedge clk_i) href_i = 0;
      repeat (2) @(negedge clk_i);
    end
    vsync_i = 1;
    repeat (4) @(negedge clk_i);
  endtask

  initial begin
    // 1: reset with DVP toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      vsync_i = i[0];
      href_i = ~i[0];
      data_i = 8'($urandom);
      @(posedge clk_i) #1;
      zero_outs("reset");
    end
    chk("reset strobes", n_start + n_done + pq.size(), 0);
    @(negedge clk_i);
    rst_i = 0; vsync_i = 1; href_i = 0;
    // 2: configuration not done
    enable_i = 1;
    mark();
    frame(3, -1, -1, -1);
    chk("noconf pix", pq.size() - ps, 0);
    chk("noconf start", n_start - ss, 0);
    chk("noconf cap", n_cap - cs, 0);
    // 3: clean frame
    conf_done_i = 1;
    repeat (2) @(negedge clk_i);
    bq.delete();
    mark();
    frame(3, -1, -1, -1);
    chk("s3 start", n_start - ss, 1);
    chk("s3 done", n_done - ds, 1);
    chk("s3 npix", pq.size() - ps, 12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("s3 pix%0d", i), pq[ps+i], {8'(2*i), 8'(2*i+1)});
      chk($sformatf("s3 addr%0d", i), aq[ps+i], i);
      chk($sformatf("s3 lat%0d", i), cq[ps+i] - bq[i], 2);
    end
    chk("s3 cnt", frame_cnt_o, 1);
    chk("s3 err", err_o, 0);
    // 4: enable raised mid-frame
    enable_i = 0;
    repeat (2) @(negedge clk_i);
    mark();
    frame(3, -1, 0, -1);
    chk("s4 midframe pix", pq.size() - ps, 0);
    chk("s4 midframe start", n_start - ss, 0);
    chk("s4 midframe done", n_done - ds, 0);
    mark();
    frame(3, -1, -1, -1);
    chk("s4 npix", pq.size() - ps, 12);
    chk("s4 addr0", aq[ps], 0);
    chk("s4 addr11", aq[ps+11], 11);
    chk("s4 pix11", pq[ps+11], 16'h1617);
    chk("s4 cnt", frame_cnt_o, 2);
    chk("s4 err", err_o, 0);
    // 5: odd-length line
    mark();
    frame(3, 1, -1, -1);
    chk("s5 npix", pq.size() - ps, 11);
    chk("s5 addr6", aq[ps+6], 6);
    chk("s5 pix6", pq[ps+6], 16'h0C0D);
    chk("s5 addr7", aq[ps+7], 7);
    chk("s5 pix7", pq[ps+7], 16'h0F10);
    chk("s5 pix10", pq[ps+10], 16'h1516);
    chk("s5 err", err_o, 1);
    chk("s5 cnt", frame_cnt_o, 3);
    // 6: too many lines
    mark();
    frame(4, -1, -1, -1);
    chk("s6 npix", pq.size() - ps, 12);
    chk("s6 addr last", aq[pq.size()-1], 11);
    chk("s6 pix last", pq[pq.size()-1], 16'h1617);
    chk("s6 done", n_done - ds, 1);
    chk("s6 err", err_o, 1);
    chk("s6 cnt", frame_cnt_o, 4);
    // 7: reset mid-line
    mark();
    frame(3, -1, -1, 1);
    rst_i = 1;
    @(posedge clk_i) #1;
    zero_outs("s7 reset");
    @(negedge clk_i);
    rst_i = 0; href_i = 0;
    repeat (10) @(negedge clk_i);
    chk("s7 no done", n_done - ds, 0);
    chk("s7 cnt", frame_cnt_o, 0);
    mark();
    frame(3, -1, -1, -1);
    chk("s7 start", n_start - ss, 1);
    chk("s7 npix", pq.size() - ps, 12);
    chk("s7 addr0", aq[ps], 0);
    chk("s7 pix0", pq[ps], 16'h0001);
    chk("s7 cnt2", frame_cnt_o, 1);
    chk("s7 err", err_o, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
